seq_detect_mealy_p: RTL and testbench

//  Parametrised Mealy serial-pattern detector: one input bit per enabled cycle, y flags completion
//  of PATTERN in the same cycle as the completing bit. Generalises the 2-bit hand-coded Mealy FSM to
//  any pattern length, with run-time overlap/non-overlap mode and an optional saturating match counter.

---
 rtl/seq_detect_mealy_p.sv | 102 ++++++++++
 tb/tb_seq_detect_mealy_p.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_mealy_p.sv
// Parametrised Mealy serial-pattern detector with overlap/non-overlap mode.
// Optional saturating match counter enabled by defining SEQDET_COUNT_EN.
module seq_detect_mealy_p #(
  parameter int unsigned           PAT_W   = 4,
  parameter logic [PAT_W-1:0]      PATTERN = 4'b1011,
  parameter int unsigned           CNT_W   = 8,
  localparam int unsigned          SW      = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned TBL_N = 2 ** (SW + 1);

  // No-match successor of prefix length s on bit b: longest k < PAT_W such that
  // the last k bits of (PATTERN prefix of length s, b) are a prefix of PATTERN.
  function automatic logic [SW-1:0] f_next(input int unsigned s, input logic b);
    logic [SW-1:0] res;
    logic          ok;
    logic          bit_v;
    int unsigned   pos;
    res = '0;
    if (s < PAT_W) begin
      for (int unsigned k = 1; k <= s + 1; k++) begin
        if (k < PAT_W) begin
          ok = 1'b1;
          for (int unsigned j = 0; j < k; j++) begin
            pos   = s + 1 - k + j;
            bit_v = (pos == s) ? b : PATTERN[PAT_W-1-pos];
            if (bit_v != PATTERN[PAT_W-1-j]) ok = 1'b0;
          end
          if (ok) res = SW'(k);
        end
      end
    end
    return res;
  endfunction

  // Longest proper prefix of PATTERN that is also a suffix of PATTERN.
  function automatic logic [SW-1:0] f_border();
    logic [SW-1:0] res;
    logic          ok;
    res = '0;
    for (int unsigned k = 1; k < PAT_W; k++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < k; j++) begin
        if (PATTERN[PAT_W-1-j] != PATTERN[k-1-j]) ok = 1'b0;
      end
      if (ok) res = SW'(k);
    end
    return res;
  endfunction

  localparam logic [SW-1:0] BORDER = f_border();

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_nxt_tbl [TBL_N];
  logic          w_match;

  // Table indexed by {state, x}; unreachable rows (state >= PAT_W) map to 0.
  for (genvar gi = 0; gi < TBL_N; gi++) begin : g_tbl
    localparam logic [SW-1:0] NXT = f_next(gi / 2, 1'(gi % 2));
    assign w_nxt_tbl[gi] = NXT;
  end

  assign w_match = rst_n & en & (r_state == SW'(PAT_W - 1)) & (x == PATTERN[0]);
  assign y       = w_match;
  assign state   = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= '0;
    end else if (en) begin
      if (w_match) r_state <= overlap ? BORDER : '0;
      else         r_state <= w_nxt_tbl[{r_state, x}];
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (cnt_clr)                r_cnt <= '0;
    else if (w_match && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign match_cnt = r_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign match_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_detect_mealy_p.sv
// Bench for seq_detect_mealy_p: directed scenarios plus random traffic checked
// against a bit-history reference model; two instances (CNT_W=8 and CNT_W=2).
module tb_seq_detect_mealy_p;

  localparam int unsigned   PAT_W = 4;
  localparam logic [3:0]    PAT   = 4'b1011;

  logic       clk = 1'b0;
  logic       rst_n, en, x, overlap, cnt_clr;
  logic       y, y2;
  logic [1:0] state, state2;
  logic [7:0] match_cnt;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;

  logic hist[$];
  int   m_cnt8, m_cnt2;
  logic obs_y;

  seq_detect_mealy_p #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .overlap(overlap), .cnt_clr(cnt_clr),
    .y(y), .state(state), .match_cnt(match_cnt)
  );

  seq_detect_mealy_p #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .overlap(overlap), .cnt_clr(cnt_clr),
    .y(y2), .state(state2), .match_cnt(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Longest suffix of the accepted history that is a proper prefix of PAT.
  function automatic int m_state();
    int n = hist.size();
    for (int k = PAT_W - 1; k > 0; k--) begin
      if (k <= n) begin
        bit ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (hist[n-k+j] != PAT[PAT_W-1-j]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  // Would history followed by b end with the whole pattern?
  function automatic bit m_match(input logic b);
    int n = hist.size();
    if (n < PAT_W - 1) return 1'b0;
    if (b != PAT[0]) return 1'b0;
    for (int j = 0; j < PAT_W - 1; j++)
      if (hist[n-(PAT_W-1)+j] != PAT[PAT_W-1-j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input logic r, input logic e, input logic b, input logic ov, input logic clr);
    logic ey;
    @(negedge clk);
    rst_n = r; en = e; x = b; overlap = ov; cnt_clr = clr;
    #1;
    ey = r & e & m_match(b);
    obs_y = y;
    chk("y", 32'(y), 32'(ey));
    chk("y2", 32'(y2), 32'(ey));
    chk("state", 32'(state), 32'(m_state()));
    chk("state2", 32'(state2), 32'(m_state()));
`ifdef SEQDET_COUNT_EN
    chk("cnt8", 32'(match_cnt), 32'(m_cnt8));
    chk("cnt2", 32'(cnt2), 32'(m_cnt2));
`else
    chk("cnt8", 32'(match_cnt), 32'd0);
    chk("cnt2", 32'(cnt2), 32'd0);
`endif
    @(posedge clk);
    if (!r) begin
      hist.delete();
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else begin
      if (clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (ey) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
      if (e) begin
        if (ey && !ov) hist.delete();
        else begin
          hist.push_back(b);
          while (hist.size() > PAT_W) void'(hist.pop_front());
        end
      end
    end
  endtask

  task automatic stream(input logic [15:0] bits, input int n, input logic ov);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, v[i], ov, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; x = 1'b0; overlap = 1'b0; cnt_clr = 1'b0;
    m_cnt8 = 0; m_cnt2 = 0;

    // 1: reset with x=1
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t1_state", 32'(state), 32'd0);

    // 2: overlap stream 1011011
    stream(16'b1011011, 7, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SEQDET_COUNT_EN
    chk("t2_cnt", 32'(match_cnt), 32'd2);
`endif
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: non-overlap, same stream
    stream(16'b1011011, 7, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_state", 32'(state), 32'd1);
`ifdef SEQDET_COUNT_EN
    chk("t3_cnt", 32'(match_cnt), 32'd1);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: stall with en=0 at state 3
    stream(16'b101, 3, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_state", 32'(state), 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_y", 32'(obs_y), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 5: five overlapped matches saturate the 2-bit counter, then clear on a match
    stream(16'b1011011011011011, 16, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SEQDET_COUNT_EN
    chk("t5_cnt2", 32'(cnt2), 32'd0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: reset mid-sequence
    stream(16'b101, 3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_y", 32'(obs_y), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_state", 32'(state), 32'd1);

    // random traffic, biased toward pattern-like streams
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 29) == 0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
